// File: rtl/latency_responder.sv
// latency_responder: accepts issues with a per-issue latency and retires them in order
// once their deadline has passed, dropping issues that arrive while the FIFO is full.
module latency_responder #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int LAT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue,
    input  logic [LAT_W-1:0]           lat,
    input  logic                       clear,
    output logic                       retire,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_r,
    output logic                       full,
    output logic [W-1:0]               drop_cnt_r
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic [W-1:0]  now_r;
    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  leff;
    logic [W-1:0]  diff;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;

    // The head is due once now_r has reached its deadline in modular (half-range) order.
    always_comb begin
        full = outstanding_r == OW'(DEPTH);
        leff = (lat == '0) ? W'(1) : W'(lat);
        diff = now_r - mem[rd_ptr];
        push = issue && !full && !clear;
        drop = issue && full && !clear;
        pop  = (outstanding_r != '0) && !diff[W-1] && !clear;
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= now_r + leff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now_r         <= '0;
            retire        <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outstanding_r <= '0;
            drop_cnt_r    <= '0;
        end else begin
            now_r  <= now_r + W'(1);
            retire <= pop;
            if (clear) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                outstanding_r <= '0;
                drop_cnt_r    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                outstanding_r <= outstanding_r + OW'(push) - OW'(pop);
                if (drop && drop_cnt_r != '1) drop_cnt_r <= drop_cnt_r + W'(1);
            end
        end
    end
endmodule

// File: tb/tb_latency_responder.sv
// tb_latency_responder: directed and random stimulus against a queue model that tracks
// deadlines as absolute edge numbers, with an 8-bit timestamp so wrap-around is exercised.
module tb_latency_responder;
    localparam int W = 8;
    localparam int DEPTH = 8;
    localparam int LAT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue = 1'b0;
    logic [LAT_W-1:0] lat = '0;
    logic             clear = 1'b0;
    logic             retire;
    logic [3:0]       outstanding_r;
    logic             full;
    logic [W-1:0]     drop_cnt_r;

    int checks = 0;
    int errors = 0;
    int e = 0;
    int q[$];
    int drops = 0;
    int rcount = 0;
    int last_ret = -1;
    int mark;

    latency_responder #(.W(W), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst(rst), .issue(issue), .lat(lat), .clear(clear),
        .retire(retire), .outstanding_r(outstanding_r), .full(full), .drop_cnt_r(drop_cnt_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit exp_ret);
        chk("retire", 32'(retire), 32'(exp_ret));
        chk("outstanding", 32'(outstanding_r), q.size());
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("drop_cnt", 32'(drop_cnt_r), drops);
    endtask

    // One clock edge: inputs applied before it, model advanced at it, outputs checked after it.
    task automatic step(input bit iss, input int l, input bit clr);
        bit was_full;
        bit exp_ret;
        issue = iss;
        lat = LAT_W'(l);
        clear = clr;
        @(posedge clk);
        e++;
        was_full = q.size() == DEPTH;
        exp_ret = 1'b0;
        if (clr) begin
            q.delete();
            drops = 0;
        end else begin
            if (q.size() > 0 && q[0] <= e) begin
                exp_ret = 1'b1;
                void'(q.pop_front());
            end
            if (iss) begin
                if (was_full) drops = (drops == 255) ? 255 : drops + 1;
                else q.push_back(e + ((l == 0) ? 1 : l));
            end
        end
        #1;
        check_outputs(exp_ret);
        if (retire === 1'b1) begin
            rcount++;
            last_ret = e;
        end
        issue = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        q.delete();
        drops = 0;
        e = 0;
        check_outputs(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();

        // single issue, lat=5
        step(1, 5, 0);
        mark = e;
        chk("lat5_outstanding", 32'(outstanding_r), 1);
        repeat (5) step(0, 0, 0);
        chk("lat5_retire_edge", last_ret, mark + 5);
        chk("lat5_drained", 32'(outstanding_r), 0);

        // lat=0 and lat=1 each retire one edge later
        step(1, 0, 0);
        mark = e;
        step(0, 0, 0);
        chk("lat0_retire", 32'(retire), 1);
        chk("lat0_edge", last_ret, mark + 1);
        step(0, 0, 0);
        step(1, 1, 0);
        mark = e;
        step(0, 0, 0);
        chk("lat1_edge", last_ret, mark + 1);
        step(0, 0, 0);

        // fill to DEPTH behind a long-latency head, ninth issue dropped
        rcount = 0;
        step(1, 100, 0);
        repeat (7) step(1, 1, 0);
        chk("fill_full", 32'(full), 1);
        step(1, 1, 0);
        chk("fill_drop", 32'(drop_cnt_r), 1);
        repeat (110) step(0, 0, 0);
        chk("fill_retires", rcount, 8);

        // in-order retirement: short-latency B waits behind A
        step(1, 20, 0);
        mark = e;
        step(1, 2, 0);
        repeat (19) step(0, 0, 0);
        chk("order_a", last_ret, mark + 20);
        step(0, 0, 0);
        chk("order_b", last_ret, mark + 21);

        // clear with coincident issue
        repeat (3) step(1, 30, 0);
        step(1, 5, 1);
        chk("clear_outstanding", 32'(outstanding_r), 0);
        chk("clear_drops", 32'(drop_cnt_r), 0);
        rcount = 0;
        repeat (40) step(0, 0, 0);
        chk("clear_no_retire", rcount, 0);

        // timestamp wrap: issue with now_r == 250, deadline wraps to 4
        do_reset();
        while (e < 250) step(0, 0, 0);
        step(1, 10, 0);
        mark = e;
        rcount = 0;
        repeat (9) step(0, 0, 0);
        chk("wrap_early", rcount, 0);
        step(0, 0, 0);
        chk("wrap_retire", 32'(retire), 1);
        chk("wrap_edge", last_ret, mark + 10);

        // asynchronous reset mid-flight discards entries
        step(1, 10, 0);
        step(1, 3, 0);
        step(0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_out", 32'(outstanding_r), 0);
        chk("rst_async_ret", 32'(retire), 0);
        do_reset();
        rcount = 0;
        repeat (15) step(0, 0, 0);
        chk("rst_no_retire", rcount, 0);

        // random traffic across several timestamp wraps
        for (int i = 0; i < 700; i++)
            step(1'($urandom % 2), int'($urandom_range(0, 40)), ($urandom % 60) == 0);
        repeat (60) step(0, 0, 0);
        chk("random_drained", 32'(outstanding_r), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/latency_responder.md
LATENCY_RESPONDER -- requirements
Module: latency_responder

Interface
REQ-001 The module SHALL have parameter W, default 32, meaning the width of the timestamp, deadline and drop counters.
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning the maximum number of outstanding issues (power of 2, >=2).
REQ-003 The module SHALL have parameter LAT_W, default 8, meaning the width of the per-issue latency input.
REQ-004 Port clk  input  1  is the single clock; all state SHALL be updated on its rising edge.
REQ-005 Port rst  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-006 Port issue  input  1  SHALL mean that a new operation is issued this cycle; it is sampled at the rising edge.
REQ-007 Port lat  input  LAT_W  SHALL mean the requested issue-to-retire latency in cycles, sampled together with issue.
REQ-008 Port clear  input  1  SHALL mean a synchronous flush of all outstanding entries and counters.
REQ-009 Port retire  output  1  SHALL be a registered one-cycle pulse per retired operation.
REQ-010 Port outstanding_r  output  $clog2(DEPTH+1)  SHALL give the registered count of accepted but not yet retired issues.
REQ-011 Port full  output  1  SHALL be combinational, equal to (outstanding_r == DEPTH).
REQ-012 Port drop_cnt_r  output  W  SHALL give the registered count of issues rejected because the block was full.

Function
REQ-013 A free-running counter now_r (W bits) SHALL increment every cycle and wrap modulo 2^W.
REQ-014 The effective latency Leff SHALL be lat when lat>=1, and SHALL be 1 when lat==0.
REQ-015 An issue sampled at edge T with full==0 and clear==0 SHALL push the deadline D = now_r + Leff (mod 2^W) into an in-order FIFO of DEPTH entries.
REQ-016 An issue sampled while full==1 SHALL be dropped; drop_cnt_r SHALL increment and saturate at 2^W-1.
REQ-017 The full flag SHALL be evaluated from outstanding_r before the edge, so an issue that arrives while full SHALL be dropped even if a pop occurs at the same edge.
REQ-018 At each edge, if the FIFO is non-empty and ((now_r - D_head) mod 2^W) < 2^(W-1), the head SHALL be popped and retire SHALL be 1 for exactly the following cycle; otherwise retire SHALL be 0.
REQ-019 At most one pop SHALL occur per cycle, and retires SHALL occur in issue order, so an entry retires at the later of T+Leff and (previous retire edge + 1).
REQ-020 An entry pushed at edge T SHALL NOT be eligible for a pop at edge T; with Leff=1, retire SHALL be high in the cycle following edge T+1.
REQ-021 A push and a pop at the same edge SHALL leave outstanding_r unchanged.
REQ-022 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-023 When clear is 1 at an edge, the FIFO SHALL be emptied, outstanding_r and drop_cnt_r SHALL be zeroed, and retire SHALL be 0 for the next cycle.
REQ-024 An issue coincident with clear SHALL be discarded and SHALL NOT be counted as a drop.
REQ-025 Clear SHALL NOT reset now_r.

Reset
REQ-026 While rst is high, now_r, outstanding_r, drop_cnt_r, retire, and both FIFO pointers SHALL be 0, and full SHALL be 0.
REQ-027 Assertion of rst mid-operation SHALL immediately discard all outstanding entries, and no retire SHALL be produced for them after reset releases.
REQ-028 FIFO storage SHALL NOT require reset.

Verification
REQ-029 Single issue, lat=5 at edge T: outstanding_r=1 after T, retire high only in the cycle after edge T+5, and outstanding_r=0 after T+5.
REQ-030 lat=0 and lat=1 issues on separate occasions: each retires one cycle later (retire high after edge T+1).
REQ-031 Issues with lat=1 on 9 consecutive cycles, DEPTH=8, all retires blocked, i.e. lat=100 on the first: full=1 after the 8th issue, the 9th is dropped, drop_cnt_r=1; after draining, exactly 8 retire pulses.
REQ-032 Issue A lat=20 at T, issue B lat=2 at T+1: B retires at edge T+21, the edge after A at T+20, preserving order.
REQ-033 Three outstanding issues, clear asserted with issue high at the same edge: outstanding_r=0, drop_cnt_r=0, and no retire pulses afterward.
REQ-034 W=8 bench with now_r near 250, issue lat=10: the deadline wraps to 4 and retire occurs exactly 10 edges later; rst mid-flight yields no retire.
